cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It steps each instruction through BOOT/FETCH/DECODE/EXEC/MEM/WB phases and drives the write enables and mux selects of the shared datapath (PC, IR, register file, ALU, data memory). It handles the instruction- and data-memory ready handshakes, times out stalled memory accesses, and supports a debug halt. It also maintains the retired-instruction counter.

---
 rtl/cpu_sequencer_pkg.sv | 55 +++++
 rtl/cpu_sequencer_if.sv | 43 ++++
 rtl/cpu_sequencer_class_decode.sv | 35 +++
 rtl/cpu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// ============================================================================
// Module   : cpu_sequencer_pkg
// Brief    : Shared opcode classes, state encodings and mux select codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_sequencer_pkg;

   localparam int OPCODE_WIDTH = 7;

   // Opcode classes, keyed on opcode[6:2]
   localparam logic [4:0] OPC_IMML   = 5'b00000;
   localparam logic [4:0] OPC_IMMOP  = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_REG    = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [1:0] PC_SEL_PC4    = 2'd0;
   localparam logic [1:0] PC_SEL_TARGET = 2'd1;
   localparam logic [1:0] PC_SEL_ALU    = 2'd2;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   typedef struct packed {
      logic is_reg;
      logic is_immop;
      logic is_imml;
      logic is_store;
      logic is_branch;
      logic is_lui;
      logic is_auipc;
      logic is_jal;
      logic is_jalr;
   } cls_t;

endpackage

`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
// ============================================================================
// Module   : cpu_sequencer_if
// Brief    : Sequencer <-> datapath/memory control bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cpu_sequencer_if
   import cpu_sequencer_pkg::*;
();
   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    branch_taken;
   logic                    imem_ready;
   logic                    dmem_ready;
   logic                    halt_req;
   logic                    imem_req;
   logic                    ir_we;
   logic                    alu_en;
   logic                    dmem_req;
   logic                    dmem_we;
   logic                    rf_we;
   logic [1:0]              wb_sel;
   logic                    pc_we;
   logic [1:0]              pc_sel;
   logic                    illegal_insn;
   logic                    bus_err;
   logic                    halted;
   logic [31:0]             instret;

   modport master (
      input  opcode, branch_taken, imem_ready, dmem_ready, halt_req,
      output imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, wb_sel,
             pc_we, pc_sel, illegal_insn, bus_err, halted, instret
   );

   modport slave (
      output opcode, branch_taken, imem_ready, dmem_ready, halt_req,
      input  imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, wb_sel,
             pc_we, pc_sel, illegal_insn, bus_err, halted, instret
   );
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer_class_decode.sv
// ============================================================================
// Module   : seq_class_decode
// Brief    : opcode[6:2] to one-hot instruction class plus illegal flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_class_decode
   import cpu_sequencer_pkg::*;
(
   input  logic [4:0] opclass,
   output cls_t       cls,
   output logic       illegal
);

   always_comb begin
      cls     = '0;
      illegal = 1'b0;
      case (opclass)
         OPC_REG:    cls.is_reg    = 1'b1;
         OPC_IMMOP:  cls.is_immop  = 1'b1;
         OPC_IMML:   cls.is_imml   = 1'b1;
         OPC_STORE:  cls.is_store  = 1'b1;
         OPC_BRANCH: cls.is_branch = 1'b1;
         OPC_LUI:    cls.is_lui    = 1'b1;
         OPC_AUIPC:  cls.is_auipc  = 1'b1;
         OPC_JAL:    cls.is_jal    = 1'b1;
         OPC_JALR:   cls.is_jalr   = 1'b1;
         default:    illegal       = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle RV32I control sequencer with memory timeout and halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   cpu_sequencer_if.master bus
);

   localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

   state_t      r_state;
   state_t      w_next;
   state_t      w_boundary;
   logic [7:0]  r_wait_cnt;
   logic        r_fault;
   logic [31:0] r_instret;
   cls_t        w_cls;
   logic        w_illegal;
   logic        w_retire;
   logic        w_wait_inc;
   logic        w_set_fault;
   logic        w_unused_opbits;

   assign w_unused_opbits = ^bus.opcode[1:0];

   seq_class_decode u_class_decode (
      .opclass (bus.opcode[6:2]),
      .cls     (w_cls),
      .illegal (w_illegal)
   );

   // Every instruction boundary diverts to HALT while a halt is requested
   assign w_boundary = bus.halt_req ? ST_HALT : ST_FETCH;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_wait_cnt <= 8'd0;
         r_fault    <= 1'b0;
         r_instret  <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_wait_cnt <= 8'd0;
         end else if (w_wait_inc) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
         if (w_set_fault) begin
            r_fault <= 1'b1;
         end
         if (w_retire) begin
            r_instret <= r_instret + 32'd1;
         end
      end
   end

   always_comb begin
      w_next           = r_state;
      w_retire         = 1'b0;
      w_wait_inc       = 1'b0;
      w_set_fault      = 1'b0;
      bus.imem_req     = 1'b0;
      bus.ir_we        = 1'b0;
      bus.alu_en       = 1'b0;
      bus.dmem_req     = 1'b0;
      bus.dmem_we      = 1'b0;
      bus.rf_we        = 1'b0;
      bus.wb_sel       = WB_SEL_ALU;
      bus.pc_we        = 1'b0;
      bus.pc_sel       = PC_SEL_PC4;
      bus.illegal_insn = 1'b0;
      bus.bus_err      = 1'b0;
      bus.halted       = 1'b0;

      case (r_state)
         ST_BOOT: w_next = w_boundary;

         ST_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_we = 1'b1;
               w_next    = ST_DECODE;
            end else if (r_wait_cnt == C_TIMEOUT) begin
               bus.bus_err = 1'b1;
               w_set_fault = 1'b1;
               w_next      = ST_HALT;
            end else begin
               w_wait_inc = 1'b1;
            end
         end

         ST_DECODE: begin
            if (w_illegal) begin
               bus.illegal_insn = 1'b1;
               bus.pc_we        = 1'b1;
               w_next           = w_boundary;
            end else begin
               w_next = ST_EXEC;
            end
         end

         ST_EXEC: begin
            bus.alu_en = 1'b1;
            if (w_cls.is_branch) begin
               bus.pc_we  = 1'b1;
               bus.pc_sel = bus.branch_taken ? PC_SEL_TARGET : PC_SEL_PC4;
               w_retire   = 1'b1;
               w_next     = w_boundary;
            end else if (w_cls.is_imml || w_cls.is_store) begin
               w_next = ST_MEM;
            end else begin
               w_next = ST_WB;
            end
         end

         ST_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = w_cls.is_store;
            if (bus.dmem_ready) begin
               if (w_cls.is_store) begin
                  bus.pc_we = 1'b1;
                  w_retire  = 1'b1;
                  w_next    = w_boundary;
               end else begin
                  w_next = ST_WB;
               end
            end else if (r_wait_cnt == C_TIMEOUT) begin
               bus.bus_err = 1'b1;
               w_set_fault = 1'b1;
               w_next      = ST_HALT;
            end else begin
               w_wait_inc = 1'b1;
            end
         end

         ST_WB: begin
            bus.rf_we = 1'b1;
            bus.pc_we = 1'b1;
            w_retire  = 1'b1;
            w_next    = w_boundary;
            if (w_cls.is_imml) begin
               bus.wb_sel = WB_SEL_MEM;
            end else if (w_cls.is_jal) begin
               bus.wb_sel = WB_SEL_PC4;
               bus.pc_sel = PC_SEL_TARGET;
            end else if (w_cls.is_jalr) begin
               bus.wb_sel = WB_SEL_PC4;
               bus.pc_sel = PC_SEL_ALU;
            end
         end

         ST_HALT: begin
            bus.halted = 1'b1;
            // A memory fault pins the sequencer here until reset
            if (!bus.halt_req && !r_fault) begin
               w_next = ST_FETCH;
            end
         end

         default: w_next = ST_BOOT;
      endcase
   end

   assign bus.instret = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Directed self-checking bench for cpu_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cpu_sequencer_if bus ();

   cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.opcode = 7'h00;
      bus.branch_taken = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.halt_req = 1'b0;
      #2;
      check("rst_imem_req", bus.imem_req, 0);
      check("rst_halted", bus.halted, 0);
      check("rst_instret", bus.instret, 0);
      check("rst_pc_we", bus.pc_we, 0);

      cycle(); rst = 1'b0; #1;
      check("boot_imem_req", bus.imem_req, 0);

      // ADDI, zero wait
      cycle(); bus.opcode = 7'h13; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; #1;
      check("addi_fetch_req", bus.imem_req, 1);
      check("addi_fetch_irwe", bus.ir_we, 1);
      cycle(); #1;
      check("addi_dec_irwe", bus.ir_we, 0);
      check("addi_dec_pcwe", bus.pc_we, 0);
      check("addi_dec_alu", bus.alu_en, 0);
      cycle(); #1;
      check("addi_exec_alu", bus.alu_en, 1);
      check("addi_exec_pcwe", bus.pc_we, 0);
      cycle(); #1;
      check("addi_wb_rfwe", bus.rf_we, 1);
      check("addi_wb_wbsel", bus.wb_sel, 0);
      check("addi_wb_pcwe", bus.pc_we, 1);
      check("addi_wb_pcsel", bus.pc_sel, 0);

      // LW with dmem_ready delayed 3 cycles
      cycle(); bus.opcode = 7'h03; bus.dmem_ready = 1'b0; #1;
      check("addi_instret", bus.instret, 1);
      check("lw_fetch_irwe", bus.ir_we, 1);
      cycle(); #1;
      cycle(); #1;
      check("lw_exec_alu", bus.alu_en, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(); #1;
         check("lw_mem_wait_req", bus.dmem_req, 1);
         check("lw_mem_wait_we", bus.dmem_we, 0);
      end
      cycle(); bus.dmem_ready = 1'b1; #1;
      check("lw_mem_last_req", bus.dmem_req, 1);
      check("lw_mem_rfwe", bus.rf_we, 0);
      cycle(); #1;
      check("lw_wb_rfwe", bus.rf_we, 1);
      check("lw_wb_wbsel", bus.wb_sel, 1);
      check("lw_wb_pcsel", bus.pc_sel, 0);

      // BEQ taken then not taken
      cycle(); bus.opcode = 7'h63; bus.branch_taken = 1'b1; #1;
      check("lw_instret", bus.instret, 2);
      check("beq1_fetch_req", bus.imem_req, 1);
      cycle(); #1;
      cycle(); #1;
      check("beq1_exec_pcwe", bus.pc_we, 1);
      check("beq1_exec_pcsel", bus.pc_sel, 1);
      check("beq1_exec_rfwe", bus.rf_we, 0);
      cycle(); bus.branch_taken = 1'b0; #1;
      check("beq1_instret", bus.instret, 3);
      check("beq2_fetch_req", bus.imem_req, 1);
      cycle(); #1;
      cycle(); #1;
      check("beq2_exec_pcwe", bus.pc_we, 1);
      check("beq2_exec_pcsel", bus.pc_sel, 0);
      check("beq2_exec_rfwe", bus.rf_we, 0);

      // JALR
      cycle(); bus.opcode = 7'h67; #1;
      check("beq2_instret", bus.instret, 4);
      cycle(); #1;
      cycle(); #1;
      check("jalr_exec_rfwe", bus.rf_we, 0);
      cycle(); #1;
      check("jalr_wb_rfwe", bus.rf_we, 1);
      check("jalr_wb_wbsel", bus.wb_sel, 2);
      check("jalr_wb_pcsel", bus.pc_sel, 2);

      // SW, zero wait
      cycle(); bus.opcode = 7'h23; #1;
      check("jalr_instret", bus.instret, 5);
      cycle(); #1;
      cycle(); #1;
      cycle(); #1;
      check("sw_mem_req", bus.dmem_req, 1);
      check("sw_mem_we", bus.dmem_we, 1);
      check("sw_mem_pcwe", bus.pc_we, 1);
      check("sw_mem_pcsel", bus.pc_sel, 0);
      check("sw_mem_rfwe", bus.rf_we, 0);

      // Undefined opcode class
      cycle(); bus.opcode = 7'h7F; #1;
      check("sw_instret", bus.instret, 6);
      cycle(); #1;
      check("ill_dec_pulse", bus.illegal_insn, 1);
      check("ill_dec_pcwe", bus.pc_we, 1);
      check("ill_dec_pcsel", bus.pc_sel, 0);
      cycle(); bus.opcode = 7'h6F; #1;
      check("ill_pulse_end", bus.illegal_insn, 0);
      check("ill_instret", bus.instret, 6);
      check("ill_back_fetch", bus.imem_req, 1);

      // JAL
      cycle(); #1;
      cycle(); #1;
      cycle(); #1;
      check("jal_wb_wbsel", bus.wb_sel, 2);
      check("jal_wb_pcsel", bus.pc_sel, 1);
      check("jal_wb_rfwe", bus.rf_we, 1);

      // Halt requested while a load is in MEM
      cycle(); bus.opcode = 7'h03; bus.dmem_ready = 1'b0; #1;
      check("jal_instret", bus.instret, 7);
      cycle(); #1;
      cycle(); #1;
      cycle(); bus.halt_req = 1'b1; #1;
      check("hlw_mem_req", bus.dmem_req, 1);
      check("hlw_mem_halted", bus.halted, 0);
      cycle(); bus.dmem_ready = 1'b1; #1;
      check("hlw_mem2_req", bus.dmem_req, 1);
      cycle(); #1;
      check("hlw_wb_rfwe", bus.rf_we, 1);
      check("hlw_wb_wbsel", bus.wb_sel, 1);
      check("hlw_wb_halted", bus.halted, 0);
      cycle(); #1;
      check("halt_halted", bus.halted, 1);
      check("halt_no_req", bus.imem_req, 0);
      check("halt_instret", bus.instret, 8);
      cycle(); bus.halt_req = 1'b0; bus.imem_ready = 1'b0; bus.opcode = 7'h13; #1;
      check("halt_hold", bus.halted, 1);

      // Ready in the same cycle the counter reaches the limit wins
      cycle(); #1;
      check("resume_halted", bus.halted, 0);
      check("resume_req", bus.imem_req, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(); #1;
         check("edge_wait_err", bus.bus_err, 0);
      end
      cycle(); bus.imem_ready = 1'b1; #1;
      check("edge_irwe", bus.ir_we, 1);
      check("edge_no_err", bus.bus_err, 0);
      cycle(); #1;
      cycle(); #1;
      cycle(); #1;
      check("edge_wb_rfwe", bus.rf_we, 1);

      // Fetch timeout: four wait cycles, then bus_err and sticky HALT
      cycle(); bus.imem_ready = 1'b0; #1;
      check("edge_instret", bus.instret, 9);
      for (int i = 0; i < 3; i++) begin
         cycle(); #1;
         check("to_wait_err", bus.bus_err, 0);
         check("to_wait_req", bus.imem_req, 1);
      end
      cycle(); #1;
      check("to_bus_err", bus.bus_err, 1);
      cycle(); #1;
      check("to_halted", bus.halted, 1);
      check("to_err_pulse", bus.bus_err, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(); #1;
      end
      check("to_sticky_halted", bus.halted, 1);
      check("to_sticky_req", bus.imem_req, 0);

      // Asynchronous reset clears the fault
      #1; rst = 1'b1; #1;
      check("arst_halted", bus.halted, 0);
      check("arst_instret", bus.instret, 0);

      // Reset in WB suppresses the write strobes immediately
      cycle(); rst = 1'b0; bus.imem_ready = 1'b1; #1;
      cycle(); #1;
      check("post_rst_irwe", bus.ir_we, 1);
      cycle(); #1;
      cycle(); #1;
      cycle(); #1;
      check("mid_wb_rfwe", bus.rf_we, 1);
      #1; rst = 1'b1; #1;
      check("mid_rst_rfwe", bus.rf_we, 0);
      check("mid_rst_pcwe", bus.pc_we, 0);
      check("mid_rst_instret", bus.instret, 0);

      cycle();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
